// File: rtl/neuromorphic_x1_wb_initiator.sv
// Wishbone slave that turns bus cycles into NEUROMORPHIC_X1 macro EN/R_WB accesses,
// tracking pending-write occupancy and bounding each macro access with a timeout.
module neuromorphic_x1_wb_initiator #(
  parameter int          DEPTH       = 32,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] STATUS_ADR  = 32'h0000_0004
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        mac_en,
  output logic        mac_r_wb,
  output logic [31:0] mac_di,
  output logic [31:0] mac_ad,
  output logic [3:0]  mac_sel,
  input  logic [31:0] mac_do,
  input  logic        mac_func_ack,
  output logic [5:0]  pend_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, STAT, WR_WAIT, RD_WAIT, ERR, RESP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [5:0]    pend_q, pend_d;
  logic [31:0]   dat_o_q, dat_o_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          en_q, en_d;
  logic          r_wb_q, r_wb_d;
  logic [31:0]   di_q, di_d;
  logic [31:0]   ad_q, ad_d;
  logic [3:0]    sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    dat_o_d = dat_o_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    en_d    = en_q;
    r_wb_d  = r_wb_q;
    di_d    = di_q;
    ad_d    = ad_q;
    sel_d   = sel_q;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          tmo_d = '0;
          if (wb_adr_i[7:0] == STATUS_ADR[7:0]) begin
            state_d = STAT;
          end else if ((wb_we_i && (pend_q == 6'(DEPTH))) || (!wb_we_i && (pend_q == 6'd0))) begin
            state_d = ERR;
          end else begin
            en_d    = 1'b1;
            r_wb_d  = !wb_we_i;
            ad_d    = wb_adr_i;
            sel_d   = wb_sel_i;
            di_d    = wb_we_i ? wb_dat_i : 32'd0;
            state_d = wb_we_i ? WR_WAIT : RD_WAIT;
          end
        end
      end

      STAT: begin
        ack_d   = 1'b1;
        dat_o_d = {26'd0, pend_q};
        state_d = RESP;
      end

      ERR: begin
        err_d   = 1'b1;
        state_d = RESP;
      end

      // An abandoned bus cycle aborts silently; a macro ack beats a simultaneous timeout.
      WR_WAIT, RD_WAIT: begin
        if (!wb_cyc_i) begin
          en_d    = 1'b0;
          state_d = IDLE;
        end else if (mac_func_ack) begin
          en_d    = 1'b0;
          ack_d   = 1'b1;
          state_d = RESP;
          if (state_q == WR_WAIT) begin
            if (pend_q != 6'(DEPTH)) pend_d = pend_q + 6'd1;
          end else begin
            dat_o_d = mac_do;
            if (pend_q != 6'd0) pend_d = pend_q - 6'd1;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      pend_q  <= '0;
      dat_o_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      r_wb_q  <= 1'b0;
      di_q    <= '0;
      ad_q    <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      dat_o_q <= dat_o_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      en_q    <= en_d;
      r_wb_q  <= r_wb_d;
      di_q    <= di_d;
      ad_q    <= ad_d;
      sel_q   <= sel_d;
    end
  end

  assign wb_dat_o = dat_o_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign mac_en   = en_q;
  assign mac_r_wb = r_wb_q;
  assign mac_di   = di_q;
  assign mac_ad   = ad_q;
  assign mac_sel  = sel_q;
  assign pend_cnt = pend_q;

endmodule

// File: tb/tb_neuromorphic_x1_wb_initiator.sv
// Bench for neuromorphic_x1_wb_initiator: behavioural FIFO-style ReRAM macro, directed
// vector table, randomized traffic against a transaction-level model, and corner sequences.
module tb_neuromorphic_x1_wb_initiator;

  localparam int DEPTH       = 32;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack, err;
  logic        mac_en, mac_r_wb;
  logic [31:0] mac_di, mac_ad, mac_do;
  logic [3:0]  mac_sel;
  logic        model_ack, stray_ack;
  logic        mac_func_ack;
  logic [5:0]  pend_cnt;

  assign mac_func_ack = model_ack | stray_ack;

  neuromorphic_x1_wb_initiator #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC), .STATUS_ADR(32'h0000_0004)) dut (
    .CLKin(clk), .RSTin(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .mac_en(mac_en), .mac_r_wb(mac_r_wb), .mac_di(mac_di), .mac_ad(mac_ad), .mac_sel(mac_sel),
    .mac_do(mac_do), .mac_func_ack(mac_func_ack), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Macro stand-in: func_ack rises lat-1 cycles after EN, so bus latency equals lat.
  int         wr_lat = 1;
  int         rd_lat = 45;
  logic       ack_enable = 1'b1;
  logic [7:0] mac_q[$];
  int         busy_cnt;

  initial begin
    model_ack = 1'b0;
    mac_do    = 32'd0;
    busy_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      model_ack = 1'b0;
      if (rst) begin
        mac_q.delete();
        busy_cnt = 0;
      end else if (mac_en && ack_enable) begin
        busy_cnt++;
        if (busy_cnt == (mac_r_wb ? rd_lat : wr_lat)) begin
          model_ack = 1'b1;
          if (mac_r_wb) begin
            if (mac_q.size() > 0) mac_do = {24'd0, mac_q.pop_front()};
            else mac_do = 32'd0;
          end else begin
            mac_q.push_back(mac_di[7:0]);
          end
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Transaction-level expectation state
  int          exp_pend;
  logic [7:0]  exp_q[$];
  logic [31:0] last_data;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_dat_o"}, dat_o, 32'd0);
    checkOutput({tag, "_mac_en"}, 32'(mac_en), 32'd0);
    checkOutput({tag, "_mac_r_wb"}, 32'(mac_r_wb), 32'd0);
    checkOutput({tag, "_mac_di"}, mac_di, 32'd0);
    checkOutput({tag, "_mac_ad"}, mac_ad, 32'd0);
    checkOutput({tag, "_mac_sel"}, 32'(mac_sel), 32'd0);
    checkOutput({tag, "_pend"}, 32'(pend_cnt), 32'd0);
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic got_ack, output logic got_err, output int cycles,
                               output logic en_seen, output logic en_end, output logic pulse_ok,
                               output logic [31:0] cap_ad, output logic [31:0] cap_di,
                               output logic [3:0] cap_sel, output logic cap_rwb);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    en_seen = mac_en;
    cap_ad = mac_ad; cap_di = mac_di; cap_sel = mac_sel; cap_rwb = mac_r_wb;
    got_ack = 1'b0; got_err = 1'b0; cycles = 0;
    while (!got_ack && !got_err && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      got_ack = ack;
      got_err = err;
      if (!got_ack && !got_err && mac_en) en_seen = 1'b1;
    end
    en_end = mac_en;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    pulse_ok = !ack && !err;
  endtask

  // Predicts each transfer from occupancy rules and macro latency, then compares.
  task automatic modelOp(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic g_ack, g_err, en_seen, en_end, pulse_ok, c_rwb;
    logic [31:0] c_ad, c_di;
    logic [3:0] c_sel;
    int cycles, lat, e_cyc;
    logic e_ack, e_err, e_mac;
    lat = w ? wr_lat : rd_lat;
    e_mac = 1'b0;
    if (a[7:0] == 8'h04) begin
      e_ack = 1'b1; e_err = 1'b0; e_cyc = 1;
      last_data = 32'(exp_pend);
    end else if ((w && exp_pend == DEPTH) || (!w && exp_pend == 0)) begin
      e_ack = 1'b0; e_err = 1'b1; e_cyc = 1;
    end else begin
      e_mac = 1'b1;
      if (!ack_enable || lat > TIMEOUT_CYC) begin
        e_ack = 1'b0; e_err = 1'b1; e_cyc = TIMEOUT_CYC;
      end else begin
        e_ack = 1'b1; e_err = 1'b0; e_cyc = lat;
        if (w) begin
          exp_q.push_back(d[7:0]);
          exp_pend++;
        end else begin
          last_data = {24'd0, exp_q.pop_front()};
          exp_pend--;
        end
      end
    end
    applyStimulus(w, a, d, s, g_ack, g_err, cycles, en_seen, en_end, pulse_ok, c_ad, c_di, c_sel, c_rwb);
    checkOutput({tag, "_ack"}, 32'(g_ack), 32'(e_ack));
    checkOutput({tag, "_err"}, 32'(g_err), 32'(e_err));
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(e_cyc));
    checkOutput({tag, "_pulse"}, 32'(pulse_ok), 32'd1);
    checkOutput({tag, "_mac_used"}, 32'(en_seen), 32'(e_mac));
    checkOutput({tag, "_mac_en_end"}, 32'(en_end), 32'd0);
    checkOutput({tag, "_pend"}, 32'(pend_cnt), 32'(exp_pend));
    checkOutput({tag, "_dat_o"}, dat_o, last_data);
    if (e_mac) begin
      checkOutput({tag, "_mac_ad"}, c_ad, a);
      checkOutput({tag, "_mac_di"}, c_di, w ? d : 32'd0);
      checkOutput({tag, "_mac_sel"}, 32'(c_sel), 32'(s));
      checkOutput({tag, "_mac_r_wb"}, 32'(c_rwb), 32'(!w));
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pend = 0; exp_q.delete(); last_data = 32'd0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_pend;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic g_ack, g_err, en_seen, en_end, pulse_ok, c_rwb, w, seen;
    logic [31:0] c_ad, c_di, a, d;
    logic [3:0] c_sel;
    int cycles, r;

    // Directed table with wr_lat=1, rd_lat=45 (44-cycle macro read latency)
    vecs[0] = '{1'b1, 32'h0000_0100, 32'h0A20_005A, 1'b1, 1'b0, 32'h0000_0000, 1, 1};
    vecs[1] = '{1'b0, 32'h0000_0108, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_005A, 0, 45};
    vecs[2] = '{1'b0, 32'h0000_0108, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_005A, 0, 1};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 0, 1};
    vecs[4] = '{1'b1, 32'h0000_0200, 32'h0000_00C3, 1'b1, 1'b0, 32'h0000_0000, 1, 1};
    vecs[5] = '{1'b1, 32'h0000_0300, 32'h1234_5677, 1'b1, 1'b0, 32'h0000_0000, 2, 1};
    vecs[6] = '{1'b1, 32'hABCD_0004, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0002, 2, 1};
    vecs[7] = '{1'b0, 32'h0000_010C, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_00C3, 1, 45};
    vecs[8] = '{1'b0, 32'h0000_0110, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0077, 0, 45};
    vecs[9] = '{1'b0, 32'h0000_0114, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0077, 0, 1};

    stray_ack = 1'b0;
    resetDut();
    checkAllZero("reset");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, 4'hF, g_ack, g_err, cycles, en_seen, en_end,
                    pulse_ok, c_ad, c_di, c_sel, c_rwb);
      checkOutput($sformatf("vec%0d_ack", i), 32'(g_ack), 32'(vecs[i].exp_ack));
      checkOutput($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_dat_o", i), dat_o, vecs[i].exp_dat);
      checkOutput($sformatf("vec%0d_pend", i), 32'(pend_cnt), 32'(vecs[i].exp_pend));
      checkOutput($sformatf("vec%0d_latency", i), 32'(cycles), 32'(vecs[i].exp_cyc));
      checkOutput($sformatf("vec%0d_pulse", i), 32'(pulse_ok), 32'd1);
      checkOutput($sformatf("vec%0d_mac_used", i), 32'(en_seen), 32'(vecs[i].exp_cyc > 1 || (vecs[i].we && vecs[i].exp_ack && vecs[i].adr[7:0] != 8'h04)));
    end
    exp_pend = 0; exp_q.delete(); last_data = 32'h0000_0077;

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 99));
      w = (r >= 15 && r < 60);
      a = $urandom;
      d = $urandom;
      if (r < 15) a[7:0] = 8'h04;
      else if (a[7:0] == 8'h04) a[7:0] = 8'h08;
      wr_lat = int'($urandom_range(1, 6));
      rd_lat = int'($urandom_range(2, 50));
      modelOp($sformatf("rand%0d", i), w, a, d, 4'($urandom));
    end

    // Fill to DEPTH, then the next write must be rejected
    wr_lat = 2; rd_lat = 45;
    while (exp_pend < DEPTH) modelOp("fill", 1'b1, 32'h0000_0020, $urandom, 4'hF);
    modelOp("overflow", 1'b1, 32'h0000_0020, 32'h0000_00EE, 4'hF);
    modelOp("status_full", 1'b0, 32'h0000_0004, 32'd0, 4'hF);
    checkOutput("status_full_value", dat_o, 32'd32);

    ack_enable = 1'b0;
    modelOp("timeout_rd", 1'b0, 32'h0000_0030, 32'd0, 4'hF);
    ack_enable = 1'b1;
    rd_lat = TIMEOUT_CYC;
    modelOp("ack_at_limit", 1'b0, 32'h0000_0030, 32'd0, 4'hF);
    rd_lat = TIMEOUT_CYC + 1;
    modelOp("ack_past_limit", 1'b0, 32'h0000_0030, 32'd0, 4'hF);
    rd_lat = 45;

    // Abandon a read mid-wait
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0040; sel = 4'hF;
    @(posedge clk); #1;
    checkOutput("cycdrop_en_start", 32'(mac_en), 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    checkOutput("cycdrop_en_off", 32'(mac_en), 32'd0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (ack || err) seen = 1'b1;
    end
    checkOutput("cycdrop_no_resp", 32'(seen), 32'd0);
    checkOutput("cycdrop_pend", 32'(pend_cnt), 32'(exp_pend));
    checkOutput("cycdrop_dat_o", dat_o, last_data);

    // A func_ack while idle must be ignored
    @(negedge clk);
    stray_ack = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack || err) seen = 1'b1;
    end
    @(negedge clk);
    stray_ack = 1'b0;
    checkOutput("stray_no_resp", 32'(seen), 32'd0);
    checkOutput("stray_pend", 32'(pend_cnt), 32'(exp_pend));

    // Reset in the middle of a write wait
    ack_enable = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0080; dat_i = 32'h0A20_005A; sel = 4'hF;
    @(posedge clk); #1;
    checkOutput("rstmid_en_start", 32'(mac_en), 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_en_off", 32'(mac_en), 32'd0);
    checkOutput("rstmid_no_ack", 32'(ack), 32'd0);
    checkOutput("rstmid_no_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    exp_pend = 0; exp_q.delete(); last_data = 32'd0;
    checkAllZero("rstmid");
    ack_enable = 1'b1;

    wr_lat = 3;
    modelOp("post_rst_wr", 1'b1, 32'h0000_0100, 32'h0A20_00A5, 4'h1);
    modelOp("post_rst_rd", 1'b0, 32'h0000_0100, 32'd0, 4'h1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
